// File: rtl/brtag_pkg.sv
// Shared branch-tag definitions: tag sizing, FSM encoding and the
// priority/decode helpers used by both allocation and kill logic.
package brtag_pkg;

    localparam int WIDTH_BRM = 4;
    localparam int NTAG      = 1 << WIDTH_BRM;

    typedef logic [WIDTH_BRM-1:0] tag_t;
    typedef logic [NTAG-1:0]      tagvec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_KILL,
        ST_RECOVER
    } state_t;

    function automatic tag_t lowest_free(input tagvec_t live);
        tag_t t;
        t = '0;
        for (int i = NTAG - 1; i >= 0; i--) begin
            if (!live[i]) t = tag_t'(i);
        end
        return t;
    endfunction

    function automatic tagvec_t tag2oh(input tag_t t);
        tagvec_t v;
        v    = '0;
        v[t] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/brtag_entry.sv
// State for one branch tag: liveness, ancestor set and parent link,
// plus its own kill-membership and parent-rewrite decisions.
module brtag_entry
    import brtag_pkg::*;
#(
    parameter int IDX = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    alloc_we,
    input  tagvec_t live_vec,
    input  tag_t    cur_tag,
    input  logic    cur_val,
    input  logic    res_ok,
    input  logic    res_kill,
    input  tag_t    res_tag,
    input  tag_t    res_par,
    input  logic    res_par_val,
    input  tagvec_t clr_vec,
    output logic    live,
    output tag_t    par,
    output logic    par_val,
    output logic    kill_hit
);

    localparam tag_t SELF = tag_t'(IDX);

    tagvec_t dep;
    logic    free_hit;
    logic    par_hit;
    logic    cur_resolved;

    assign kill_hit     = live & res_kill & ((res_tag == SELF) | dep[res_tag]);
    assign free_hit     = live & res_ok & (res_tag == SELF);
    assign par_hit      = par_val & res_ok & (par == res_tag);
    assign cur_resolved = res_ok & cur_val & (cur_tag == res_tag);

    // NOTE: the ancestor set is reset along with live; a stale bit left over
    // from a previous owner of a tag would otherwise kill an unrelated branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            dep     <= '0;
            par     <= '0;
            par_val <= 1'b0;
        end else if (alloc_we) begin
            live <= 1'b1;
            dep  <= live_vec & ~clr_vec;
            if (cur_resolved) begin
                par     <= res_par;
                par_val <= res_par_val;
            end else begin
                par     <= cur_tag;
                par_val <= cur_val;
            end
        end else begin
            if (kill_hit || free_hit) live <= 1'b0;
            // Freed tags drop out of every ancestor set so a reallocation starts clean.
            dep <= dep & ~clr_vec;
            if (par_hit) begin
                par     <= res_par;
                par_val <= res_par_val;
            end
        end
    end

endmodule

// File: rtl/brtag_ctrl.sv
// Branch-tag controller: tag allocation, youngest-tag tracking, kill/free
// pulse generation and the dispatch-stall recovery FSM.
module brtag_ctrl
    import brtag_pkg::*;
#(
    parameter int RECOVER_CYC = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_gnt,
    output logic [WIDTH_BRM-1:0] o_alloc_tag,
    output logic [WIDTH_BRM-1:0] o_cur_tag,
    output logic                 o_cur_val,
    input  logic                 i_res_val,
    input  logic [WIDTH_BRM-1:0] i_res_tag,
    input  logic                 i_res_mispred,
    output logic [NTAG-1:0]      o_brkill,
    output logic [NTAG-1:0]      o_brfree,
    output logic [NTAG-1:0]      o_live,
    output logic                 o_full,
    output logic                 o_dis_stall
);

    localparam int CW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    tagvec_t live_vec;
    tagvec_t kill_vec;
    tagvec_t alloc_oh;
    tagvec_t clr_vec;
    tag_t    par_arr     [NTAG];
    logic    par_val_arr [NTAG];
    logic    res_live, res_kill, res_ok;
    tag_t    res_par;
    logic    res_par_val;

    assign res_live    = i_res_val & live_vec[i_res_tag];
    assign res_kill    = res_live & i_res_mispred;
    assign res_ok      = res_live & ~i_res_mispred;
    assign res_par     = par_arr[i_res_tag];
    assign res_par_val = par_val_arr[i_res_tag];
    assign clr_vec     = res_kill ? kill_vec : (res_ok ? tag2oh(i_res_tag) : '0);

    assign o_live      = live_vec;
    assign o_full      = &live_vec;
    assign o_alloc_tag = lowest_free(live_vec);
    assign o_alloc_gnt = i_alloc_req & ~o_full & (state_q == ST_RUN) & ~res_kill;
    assign alloc_oh    = o_alloc_gnt ? tag2oh(o_alloc_tag) : '0;
    assign o_dis_stall = (state_q != ST_RUN);

    for (genvar g = 0; g < NTAG; g++) begin : g_entry
        brtag_entry #(.IDX(g)) u_entry (
            .clk         (i_clk),
            .rst_n       (i_rst_n),
            .alloc_we    (alloc_oh[g]),
            .live_vec    (live_vec),
            .cur_tag     (o_cur_tag),
            .cur_val     (o_cur_val),
            .res_ok      (res_ok),
            .res_kill    (res_kill),
            .res_tag     (i_res_tag),
            .res_par     (res_par),
            .res_par_val (res_par_val),
            .clr_vec     (clr_vec),
            .live        (live_vec[g]),
            .par         (par_arr[g]),
            .par_val     (par_val_arr[g]),
            .kill_hit    (kill_vec[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            o_cur_tag <= '0;
            o_cur_val <= 1'b0;
            o_brkill  <= '0;
            o_brfree  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            o_brkill <= res_kill ? kill_vec : '0;
            o_brfree <= clr_vec;
            if (o_alloc_gnt) begin
                o_cur_tag <= o_alloc_tag;
                o_cur_val <= 1'b1;
            end else if (res_kill || (res_ok && o_cur_val && (o_cur_tag == i_res_tag))) begin
                o_cur_tag <= res_par;
                o_cur_val <= res_par_val;
            end
        end
    end

    // NOTE: every next-state signal gets a default before the case so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (res_kill) state_d = ST_KILL;
            end
            ST_KILL: begin
                if (!res_kill) begin
                    state_d = ST_RECOVER;
                    cnt_d   = CW'(RECOVER_CYC - 1);
                end
            end
            ST_RECOVER: begin
                if (res_kill)          state_d = ST_KILL;
                else if (cnt_q == '0)  state_d = ST_RUN;
                else                   cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

endmodule
